// File: rtl/pwm_meas_pkg.sv
// Shared types and constants for the PWM measurement block and its divider.
package pwm_meas_pkg;

  typedef enum logic {
    WAIT_EDGE = 1'b0,
    MEAS      = 1'b1
  } state_e;

  localparam int unsigned DUTY_W       = 8;
  localparam int unsigned DIV_CYC      = 8;
  localparam int unsigned GLITCH_LEN   = 3;
  localparam int unsigned DIV_CNT_W    = $clog2(DIV_CYC);
  localparam int unsigned GLITCH_CNT_W = $clog2(GLITCH_LEN);

  // Shortest period whose capture can be handed to the divider.
  localparam int unsigned MIN_PERIOD   = DIV_CYC + 1;

endpackage

// File: rtl/frac_div8.sv
// 8-cycle restoring divider: q = floor(num*256/den), one quotient bit per cycle.
// done_c/q_c flag the final iteration so the caller can register the result.
module frac_div8
  import pwm_meas_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  num_i,
  input  logic [CNT_W-1:0]  den_i,
  output logic              busy_o,
  output logic              done_c,
  output logic [DUTY_W-1:0] q_c
);

  localparam int unsigned REM_W = CNT_W + 1;

  logic                 busy_q, busy_d;
  logic [DIV_CNT_W-1:0] it_q, it_d;
  logic [REM_W-1:0]     rem_q, rem_d;
  logic [CNT_W-1:0]     den_q, den_d;
  logic [DUTY_W-1:0]    quo_q, quo_d;
  logic [REM_W-1:0]     rem_sh;
  logic                 qbit;

  // One restoring step per busy cycle; remainder stays below den so REM_W never overflows.
  always_comb begin
    busy_d = busy_q;
    it_d   = it_q;
    rem_d  = rem_q;
    den_d  = den_q;
    quo_d  = quo_q;
    done_c = 1'b0;
    rem_sh = rem_q << 1;
    qbit   = (rem_sh >= REM_W'(den_q));
    q_c    = {quo_q[DUTY_W-2:0], qbit};
    if (busy_q) begin
      rem_d = qbit ? (rem_sh - REM_W'(den_q)) : rem_sh;
      quo_d = q_c;
      it_d  = it_q + DIV_CNT_W'(1);
      if (it_q == DIV_CNT_W'(DIV_CYC - 1)) begin
        busy_d = 1'b0;
        done_c = 1'b1;
      end
    end else if (start_i) begin
      busy_d = 1'b1;
      it_d   = '0;
      rem_d  = REM_W'(num_i);
      den_d  = den_i;
      quo_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      it_q   <= '0;
      rem_q  <= '0;
      den_q  <= '0;
      quo_q  <= '0;
    end else begin
      busy_q <= busy_d;
      it_q   <= it_d;
      rem_q  <= rem_d;
      den_q  <= den_d;
      quo_q  <= quo_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/pwm_meas.sv
// PWM receiver: measures high time and period of PWM_in and converts them to 8-bit duty.
// Optional 3-cycle glitch filter on the synchronized line: define PWM_MEAS_GLITCH_EN.
module pwm_meas
  import pwm_meas_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              PWM_in,
  output logic [CNT_W-1:0]  high_cnt,
  output logic [CNT_W-1:0]  period,
  output logic [DUTY_W-1:0] duty,
  output logic              meas_valid,
  output logic              meas_ovr,
  output logic              timeout
);

  logic sync1_q, sig_s_q, sig_d_q;
  logic sig_f;
  logic rise, fall;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  per_q, per_d, hi_q, hi_d;
  logic [CNT_W-1:0]  per_inc, hi_inc;
  logic [CNT_W-1:0]  to_cnt_q, to_cnt_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  cap_hi_q, cap_hi_d, cap_per_q, cap_per_d;
  logic [CNT_W-1:0]  high_q, high_d, period_q, period_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              valid_q, valid_d, ovr_q, ovr_d;

  logic              div_start, div_busy, div_done;
  logic [DUTY_W-1:0] div_q;

`ifdef PWM_MEAS_GLITCH_EN
  logic                    filt_q;
  logic [GLITCH_CNT_W-1:0] gcnt_q, gcnt_d;

  // Follow sig_s only once it has differed from the filtered level for GLITCH_LEN cycles.
  always_comb begin
    sig_f  = filt_q;
    gcnt_d = '0;
    if (sig_s_q != filt_q) begin
      if (gcnt_q == GLITCH_CNT_W'(GLITCH_LEN - 1)) begin
        sig_f = sig_s_q;
      end else begin
        gcnt_d = gcnt_q + GLITCH_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= 1'b0;
      gcnt_q <= '0;
    end else begin
      filt_q <= sig_f;
      gcnt_q <= gcnt_d;
    end
  end
`else
  always_comb sig_f = sig_s_q;
`endif

  assign rise = sig_f & ~sig_d_q;
  assign fall = ~sig_f & sig_d_q;

  frac_div8 #(
    .CNT_W (CNT_W)
  ) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (div_start),
    .num_i   (hi_q),
    .den_i   (per_q),
    .busy_o  (div_busy),
    .done_c  (div_done),
    .q_c     (div_q)
  );

  always_comb begin
    state_d   = state_q;
    per_d     = per_q;
    hi_d      = hi_q;
    to_cnt_d  = to_cnt_q;
    timeout_d = timeout_q;
    cap_hi_d  = cap_hi_q;
    cap_per_d = cap_per_q;
    high_d    = high_q;
    period_d  = period_q;
    duty_d    = duty_q;
    valid_d   = 1'b0;
    ovr_d     = 1'b0;
    div_start = 1'b0;
    per_inc   = (per_q == '1) ? per_q : per_q + CNT_W'(1);
    hi_inc    = (hi_q == '1) ? hi_q : hi_q + CNT_W'(1);

    case (state_q)
      WAIT_EDGE: begin
        if (rise) begin
          state_d = MEAS;
          per_d   = CNT_W'(1);
          hi_d    = CNT_W'(1);
        end
      end
      MEAS: begin
        if (rise) begin
          per_d = CNT_W'(1);
          hi_d  = CNT_W'(1);
          // Capture regs stay owned by the running division until it completes.
          if (!div_busy && (per_q >= CNT_W'(MIN_PERIOD))) begin
            cap_hi_d  = hi_q;
            cap_per_d = per_q;
            div_start = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end else begin
          per_d = per_inc;
          if (sig_f) hi_d = hi_inc;
        end
      end
      default: state_d = WAIT_EDGE;
    endcase

    if (div_done) begin
      valid_d  = 1'b1;
      high_d   = cap_hi_q;
      period_d = cap_per_q;
      duty_d   = div_q;
    end

    // Stuck-line detection; an edge in the limit cycle wins over the timeout.
    if (rise || fall) begin
      to_cnt_d  = '0;
      timeout_d = 1'b0;
    end else if (!timeout_q) begin
      if (to_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
        to_cnt_d  = '0;
        timeout_d = 1'b1;
        valid_d   = 1'b1;
        high_d    = '0;
        period_d  = '0;
        duty_d    = sig_f ? '1 : '0;
        state_d   = WAIT_EDGE;
      end else begin
        to_cnt_d = to_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sig_s_q   <= 1'b0;
      sig_d_q   <= 1'b0;
      state_q   <= WAIT_EDGE;
      per_q     <= '0;
      hi_q      <= '0;
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
      cap_hi_q  <= '0;
      cap_per_q <= '0;
      high_q    <= '0;
      period_q  <= '0;
      duty_q    <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      sync1_q   <= PWM_in;
      sig_s_q   <= sync1_q;
      sig_d_q   <= sig_f;
      state_q   <= state_d;
      per_q     <= per_d;
      hi_q      <= hi_d;
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
      cap_hi_q  <= cap_hi_d;
      cap_per_q <= cap_per_d;
      high_q    <= high_d;
      period_q  <= period_d;
      duty_q    <= duty_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
    end
  end

  assign high_cnt   = high_q;
  assign period     = period_q;
  assign duty       = duty_q;
  assign meas_valid = valid_q;
  assign meas_ovr   = ovr_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_pwm_meas.sv
// Directed bench for pwm_meas with a cycle-accurate reference model and scoreboard queues.
module tb_pwm_meas;

  localparam int unsigned CNT_W       = 16;
  localparam int unsigned TIMEOUT_CYC = 4096;
  localparam int          MIN_PER     = 9;
  localparam int          LAT_VALID   = 11;
  localparam int          LAT_OVR     = 3;
  localparam int          LAT_TMO     = 3;
`ifdef PWM_MEAS_GLITCH_EN
  localparam int          FILT        = 3;
`else
  localparam int          FILT        = 1;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             PWM_in;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] period;
  logic [7:0]       duty;
  logic             meas_valid;
  logic             meas_ovr;
  logic             timeout;

  pwm_meas #(
    .CNT_W       (CNT_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .PWM_in     (PWM_in),
    .high_cnt   (high_cnt),
    .period     (period),
    .duty       (duty),
    .meas_valid (meas_valid),
    .meas_ovr   (meas_ovr),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int hi;
    int per;
    int duty;
    int to;
  } exp_t;

  exp_t exp_q[$];
  int   ovr_q[$];
  exp_t mon_e;

  int checks = 0;
  int passed = 0;

  // Reference model state, indexed by the negedge at which PWM_in was driven.
  logic mf;
  int   run, armed, m_per, m_hi, last_start, stuck, to_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  task automatic model_reset();
    mf = 1'b0; run = 0; armed = 0; m_per = 0; m_hi = 0;
    last_start = -1000; stuck = 0; to_cnt = 0;
  endtask

  task automatic model_step(input logic lvl);
    logic prev;
    exp_t e;
    prev = mf;
    if (lvl != mf) begin
      run++;
      if (run == FILT) begin
        mf  = lvl;
        run = 0;
      end
    end else begin
      run = 0;
    end
    if (mf && !prev) begin
      if (armed != 0) begin
        if ((cyc - last_start >= MIN_PER) && (m_per >= MIN_PER)) begin
          e.cyc = cyc + LAT_VALID; e.hi = m_hi; e.per = m_per;
          e.duty = (m_hi * 256) / m_per; e.to = 0;
          exp_q.push_back(e);
          last_start = cyc;
        end else begin
          ovr_q.push_back(cyc + LAT_OVR);
        end
      end
      armed = 1; m_per = 1; m_hi = 1;
    end else if (armed != 0) begin
      m_per++;
      if (mf) m_hi++;
    end
    if (mf != prev) begin
      to_cnt = 0;
      stuck  = 0;
    end else if (stuck == 0) begin
      if (to_cnt == int'(TIMEOUT_CYC) - 1) begin
        e.cyc = cyc + LAT_TMO; e.hi = 0; e.per = 0;
        e.duty = mf ? 255 : 0; e.to = 1;
        exp_q.push_back(e);
        stuck = 1; armed = 0; to_cnt = 0;
      end else begin
        to_cnt++;
      end
    end
  endtask

  task automatic drive(input logic lvl, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      PWM_in = lvl;
      model_step(lvl);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_high_cnt"}, 32'(high_cnt), 32'd0);
    check({tag, "_period"}, 32'(period), 32'd0);
    check({tag, "_duty"}, 32'(duty), 32'd0);
    check({tag, "_valid"}, 32'(meas_valid), 32'd0);
    check({tag, "_ovr"}, 32'(meas_ovr), 32'd0);
    check({tag, "_timeout"}, 32'(timeout), 32'd0);
  endtask

  // Scoreboard: pop expectations on strobes, flag strobes that arrive late or never.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (meas_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'(cyc), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("valid_cycle", 32'(cyc), 32'(mon_e.cyc));
          check("high_cnt", 32'(high_cnt), 32'(mon_e.hi));
          check("period", 32'(period), 32'(mon_e.per));
          check("duty", 32'(duty), 32'(mon_e.duty));
          check("timeout_at_valid", 32'(timeout), 32'(mon_e.to));
        end
      end
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        check("missing_valid", 32'(cyc), 32'(exp_q[0].cyc));
        void'(exp_q.pop_front());
      end
      if (meas_ovr === 1'b1) begin
        if (ovr_q.size() == 0) check("unexpected_ovr", 32'(cyc), 32'd0);
        else check("ovr_cycle", 32'(cyc), 32'(ovr_q.pop_front()));
      end
      if (ovr_q.size() > 0 && ovr_q[0] < cyc) begin
        check("missing_ovr", 32'(cyc), 32'(ovr_q[0]));
        void'(ovr_q.pop_front());
      end
    end
  end

  initial begin
    rst_n  = 1'b0;
    PWM_in = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    drive(1'b0, 10);

    // Ideal 64/256 waveform
    repeat (4) begin drive(1'b1, 64); drive(1'b0, 192); end
    // Generator extremes 1/256 and 255/256
    repeat (3) begin drive(1'b1, 1); drive(1'b0, 255); end
    repeat (3) begin drive(1'b1, 255); drive(1'b0, 1); end

    // 2-cycle glitch in the low phase of a 128/256 waveform
    drive(1'b1, 128); drive(1'b0, 40); drive(1'b1, 2); drive(1'b0, 86);
    drive(1'b1, 128); drive(1'b0, 128);

    // Too-short periods, then recovery at 25/100
    repeat (4) begin drive(1'b1, 3); drive(1'b0, 3); end
    repeat (3) begin drive(1'b1, 25); drive(1'b0, 75); end

    // Stuck low, then stuck high
    drive(1'b1, 25);
    drive(1'b0, int'(TIMEOUT_CYC) + 100);
    check("timeout_stuck_low", 32'(timeout), 32'd1);
    drive(1'b1, 8);
    check("timeout_cleared", 32'(timeout), 32'd0);
    drive(1'b1, int'(TIMEOUT_CYC) + 100);
    check("timeout_stuck_high", 32'(timeout), 32'd1);
    drive(1'b0, 4);

    // Reset while the divider is mid-way through an accepted capture
    drive(1'b1, 50); drive(1'b0, 50);
    drive(1'b1, 1);
    drive(1'b1, 5);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    ovr_q.delete();
    repeat (2) @(negedge clk);
    check_all_zero("mid_reset");
    PWM_in = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 5);
    repeat (3) begin drive(1'b1, 25); drive(1'b0, 75); end
    drive(1'b1, 1);
    drive(1'b0, 30);

    check("pending_valid", 32'(exp_q.size()), 32'd0);
    check("pending_ovr", 32'(ovr_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
